// File: rtl/dxm_int_pkg.sv
// Shared constants and helpers for the dxm interrupt aggregator.
// Holds the capture-mode encoding and a popcount over the source vector.
package dxm_int_pkg;

   localparam int  MAX_SRC = 32;
   localparam logic EDGE   = 1'b1;
   localparam logic LEVEL  = 1'b0;

   function automatic int unsigned popcount(input logic [MAX_SRC-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_SRC; i++)
         n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/dxm_int_coalesce.sv
// Coalescing unit: pending-count threshold or timeout drives a
// rate-limited interrupt request that holds until nothing is pending.
module dxm_int_coalesce #(
   parameter int CNT_W = 6,
   parameter int TMR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] pend_cnt,
   input  logic [CNT_W-1:0] coal_thresh,
   input  logic [TMR_W-1:0] coal_timeout,
   output logic             int_req
);

   logic [TMR_W-1:0] r_timer;
   logic             r_int_req;
   logic             w_any;
   logic             w_tmo_hit;
   logic             w_fire;

   always_comb begin
      w_any     = (pend_cnt != '0);
      w_tmo_hit = (coal_timeout != '0) && (r_timer >= coal_timeout);
      w_fire    = w_any && ((coal_thresh <= CNT_W'(1)) ||
                            (pend_cnt >= coal_thresh) || w_tmo_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer   <= '0;
         r_int_req <= 1'b0;
      end else begin
         // Timer only runs while events wait unserviced; saturate, never wrap.
         if (!w_any || r_int_req)
            r_timer <= '0;
         else if (r_timer != '1)
            r_timer <= r_timer + TMR_W'(1);
         r_int_req <= r_int_req ? w_any : w_fire;
      end
   end

   assign int_req = r_int_req;

endmodule

// File: rtl/dxm_interrupt_coalesce.sv
// Interrupt aggregator top: per-source capture, sticky status/overflow
// with W1C clear, and a registered pending count feeding the coalescer.
module dxm_interrupt_coalesce
   import dxm_int_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int CNT_W   = 6,
   parameter int TMR_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic [NUM_SRC-1:0] edge_mode,
   input  logic [NUM_SRC-1:0] mask,
   input  logic               clr_status_1p,
   input  logic [NUM_SRC-1:0] r_din,
   input  logic [CNT_W-1:0]   coal_thresh,
   input  logic [TMR_W-1:0]   coal_timeout,
   output logic [NUM_SRC-1:0] status,
   output logic [NUM_SRC-1:0] ovf,
   output logic [CNT_W-1:0]   pend_cnt,
   output logic               int_req
);

   logic [NUM_SRC-1:0] r_src_q;
   logic [NUM_SRC-1:0] r_status;
   logic [NUM_SRC-1:0] r_ovf;
   logic [CNT_W-1:0]   r_pend_cnt;
   logic [NUM_SRC-1:0] w_ev;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_act;

   always_comb begin
      w_ev = '0;
      for (int i = 0; i < NUM_SRC; i++)
         w_ev[i] = (edge_mode[i] == EDGE) ? (src_in[i] & ~r_src_q[i])
                                          : src_in[i];
      w_clr = clr_status_1p ? r_din : '0;
      w_act = r_status & ~mask;
   end

   // History tracks the line even in reset, so a line already high
   // when reset releases is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      r_src_q <= src_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status   <= '0;
         r_ovf      <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_status   <= (r_status & ~w_clr) | w_ev;
         r_ovf      <= (r_ovf & ~w_clr) | (w_ev & r_status & ~w_clr);
         r_pend_cnt <= CNT_W'(popcount(MAX_SRC'(w_act)));
      end
   end

   dxm_int_coalesce #(
      .CNT_W (CNT_W),
      .TMR_W (TMR_W)
   ) u_coal (
      .clk          (clk),
      .rst          (rst),
      .pend_cnt     (r_pend_cnt),
      .coal_thresh  (coal_thresh),
      .coal_timeout (coal_timeout),
      .int_req      (int_req)
   );

   assign status   = r_status;
   assign ovf      = r_ovf;
   assign pend_cnt = r_pend_cnt;

endmodule
